// File: rtl/note_tone_gen.sv
// Square-wave tone generator: maps a note index to a half-period divisor, switches
// notes only on half-period boundaries and gates the high phase with a 4-level PWM.
module note_tone_gen #(
  parameter int CLK_HZ       = 5000000,
  parameter int OCTAVE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note,
  input  logic       speak,
  input  logic [1:0] vol,
  output logic       speaker,
  output logic       phase,
  output logic [3:0] cur_note,
  output logic       active
);

  if (OCTAVE_SHIFT < 0 || OCTAVE_SHIFT > 2 || CLK_HZ <= 0) begin : g_bad_param
    $error("note_tone_gen: OCTAVE_SHIFT must be 0..2 and CLK_HZ positive");
  end

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state_q, state_d;
  logic [13:0] hcnt_q, hcnt_d;
  logic [3:0]  note_q, note_d;
  logic        phase_q, phase_d;
  logic [3:0]  pwm_q;
  logic        speaker_q;
  logic        active_q;

  logic [3:0]  req;
  logic [13:0] half_per;
  logic        boundary;
  logic [4:0]  duty;
  logic        pwm_on;

  // Half-period in clock cycles at 5 MHz for chromatic C4..D5: round(2500000/f).
  function automatic logic [13:0] div_lut(input logic [3:0] n);
    case (n)
      4'd1:    div_lut = 14'd9556;
      4'd2:    div_lut = 14'd9019;
      4'd3:    div_lut = 14'd8513;
      4'd4:    div_lut = 14'd8035;
      4'd5:    div_lut = 14'd7584;
      4'd6:    div_lut = 14'd7159;
      4'd7:    div_lut = 14'd6757;
      4'd8:    div_lut = 14'd6378;
      4'd9:    div_lut = 14'd6020;
      4'd10:   div_lut = 14'd5682;
      4'd11:   div_lut = 14'd5363;
      4'd12:   div_lut = 14'd5062;
      4'd13:   div_lut = 14'd4778;
      4'd14:   div_lut = 14'd4510;
      4'd15:   div_lut = 14'd4257;
      default: div_lut = 14'd1;
    endcase
  endfunction

  assign req      = speak ? note : 4'd0;
  assign half_per = div_lut(note_q) >> OCTAVE_SHIFT;
  assign boundary = (hcnt_q == half_per - 14'd1);
  assign duty     = {1'b0, vol, 2'b00} + 5'd4;
  assign pwm_on   = ({1'b0, pwm_q} < duty);

  // Requests are only honoured at a half-period boundary so the wave never glitches;
  // leaving IDLE is the exception and starts immediately.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    note_d  = note_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        hcnt_d  = 14'd0;
        phase_d = 1'b0;
        if (req != 4'd0) begin
          note_d  = req;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (boundary) begin
          hcnt_d = 14'd0;
          if (req == 4'd0) begin
            phase_d = 1'b0;
            note_d  = 4'd0;
            state_d = IDLE;
          end else begin
            phase_d = ~phase_q;
            note_d  = req;
          end
        end else begin
          hcnt_d = hcnt_q + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= 14'd0;
      note_q    <= 4'd0;
      phase_q   <= 1'b0;
      pwm_q     <= 4'd0;
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      note_q    <= note_d;
      phase_q   <= phase_d;
      pwm_q     <= pwm_q + 4'd1;
      speaker_q <= phase_d & pwm_on;
      active_q  <= (note_d != 4'd0);
    end
  end

  assign speaker  = speaker_q;
  assign phase    = phase_q;
  assign cur_note = note_q;
  assign active   = active_q;

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Consumes the 4-bit note index and speak flag from the musical sequencer and produces the square-wave speaker drive.
- A fixed lookup turns each note index into a half-period count at the 5 MHz system clock.
- Note changes are applied only on a wave half-period boundary, so the output never glitches.
- A 4-level PWM volume gate is applied to the high phase of the wave.

Parameters:
- CLK_HZ, 5000000, system clock frequency. Documents the fixed divisor table; the table does not recompute from it.
- OCTAVE_SHIFT, 0, range 0..2. Each table divisor is right-shifted by this amount, which raises the pitch by that many octaves.

Ports:
- clk  input  1  system clock, 5 MHz
- rst  input  1  asynchronous active-high reset
- note  input  4  requested note index; 0 = silence
- speak  input  1  sound enable; when low, note is treated as 0
- vol  input  2  volume level; sampled every cycle
- speaker  output  1  PWM-gated square wave to the speaker pin
- phase  output  1  ungated square wave, for debug and scope
- cur_note  output  4  note index currently sounding
- active  output  1  high while cur_note != 0

Behaviour:
- Reset (asynchronous, rst=1):
  - speaker=0, phase=0, cur_note=0, active=0.
  - Half-period counter hcnt=0, PWM counter pwm_cnt=0.
  - All state is cleared immediately, including mid-note; sound stops within 0 cycles of assertion.
- Request: req = speak ? note : 0, evaluated combinationally each cycle.
- Divisor table, div(n) = half-period in clk cycles:
  - 1=9556, 2=9019, 3=8513, 4=8035, 5=7584, 6=7159, 7=6757, 8=6378
  - 9=6020, 10=5682, 11=5363, 12=5062, 13=4778, 14=4510, 15=4257
  - These are chromatic C4..D5: round(2500000/f).
  - After the table lookup, d = div(cur_note) >> OCTAVE_SHIFT. Counter is 14 bits wide.
- States: IDLE (cur_note=0) and PLAY (cur_note!=0).
- IDLE:
  - phase=0, hcnt held at 0.
  - When req!=0: on that clock edge cur_note<=req, hcnt<=0, phase stays 0, go to PLAY.
  - The first toggle comes d cycles later.
- PLAY:
  - hcnt increments each cycle.
  - When hcnt==d-1 (boundary): hcnt<=0, then one of:
    - req==cur_note: phase toggles.
    - req!=cur_note and req!=0: phase toggles and cur_note<=req, so the new divisor applies from the next half-period.
    - req==0: phase<=0, cur_note<=0, go to IDLE.
  - Between boundaries, req changes are ignored; only the value present at the boundary cycle matters.
  - A request pulse that comes and goes between boundaries is lost, by design.
- Boundary cases:
  - Same note repeated on consecutive sequencer steps sounds as one continuous tone: no restart, no phase discontinuity.
  - If req changes and drops to 0 within one half-period, the boundary sees 0 and the block goes IDLE.
  - IDLE to PLAY never waits for a boundary.
- Output register: active = (cur_note!=0), registered together with cur_note.
- PWM volume:
  - pwm_cnt is a free-running 4-bit counter, incrementing every cycle from reset and wrapping 15 to 0.
  - duty = 4 for vol=0, 8 for vol=1, 12 for vol=2, 16 for vol=3.
  - speaker is registered: speaker <= phase_next & (pwm_cnt < duty).
  - vol=3 makes speaker identical to phase, one cycle aligned.
  - In IDLE, speaker=0 regardless of vol.
- Latency: speaker follows phase with no additional delay; both are registered on the same edge.

Test Plan:
- Reset mid-note: play note 10, assert rst at an arbitrary cycle -> speaker/phase/cur_note/active = 0 in the same cycle, stay 0 until a request after release.
- Steady tone: speak=1, note=10, vol=3, OCTAVE_SHIFT=0 -> cur_note=10 on the next edge; phase toggles every 5682 cycles; period 11364 cycles (~440 Hz); speaker==phase.
- Boundary-aligned change: playing note 3 (8513); switch note to 6 at hcnt=100 -> that half-period still lasts 8513 cycles; cur_note becomes 6 at the boundary; later half-periods are 7159.
- Silence: playing note 8; drop speak at hcnt=10 -> phase stays active until hcnt=6377, then phase=0, cur_note=0, active=0; 16 repeated steps of note 3 produce no phase gap.
- Volume: note 1, vol=0 -> during phase=1, speaker is high exactly 4 of every 16 cycles; vol=2 gives 12/16; during phase=0, speaker=0 for all vol.
- Octave: OCTAVE_SHIFT=1, note 10 -> half-period 2841 cycles.
